// File: rtl/iod_rd_eye_train_ctrl.sv
// ----------------------------------------------------------------------------
// iod_rd_eye_train_ctrl
// Per-lane read-eye training sequencer for one IOD DQ bit. It sweeps the IOD
// dynamic delay line upward one tap at a time and samples the sticky
// EARLY/LATE eye-monitor flags at each tap. This finds the first and last
// passing taps. It then walks the delay line back down to the eye centre.
//
// Optional feature, enabled by defining IOD_RD_TRAIN_RETRY_EN:
//   A first "no left edge" (01) or "eye too narrow" (10) failure restarts the
//   sweep from LOAD once, without raising ERR. Centring failures (11) are
//   never retried.
// ----------------------------------------------------------------------------
module iod_rd_eye_train_ctrl #(
    parameter int TAP_W      = 8,
    parameter int MAX_TAP    = 127,
    parameter int SETTLE_CYC = 8,
    parameter int SAMPLE_CYC = 16,
    parameter int MIN_EYE    = 4
) (
    input  logic             FAB_CLK,
    input  logic             ARST_N,
    input  logic             START,
    input  logic             EYE_MONITOR_EARLY,
    input  logic             EYE_MONITOR_LATE,
    input  logic             DELAY_LINE_OUT_OF_RANGE,
    output logic             DELAY_LINE_LOAD,
    output logic             DELAY_LINE_MOVE,
    output logic             DELAY_LINE_DIRECTION,
    output logic             EYE_MONITOR_CLEAR_FLAGS,
    output logic             BUSY,
    output logic             DONE,
    output logic             ERR,
    output logic [1:0]       ERR_CODE,
    output logic [TAP_W-1:0] LEFT_EDGE,
    output logic [TAP_W-1:0] RIGHT_EDGE,
    output logic [TAP_W-1:0] CENTER_TAP
);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_SETTLE, S_CLEAR, S_SAMPLE,
        S_EVAL, S_STEP, S_CENTER, S_FIN,   S_FAIL
    } state_t;

    // The sweep phase also tells SETTLE where to go next: CENTERING ends in FIN.
    typedef enum logic [1:0] {
        PH_SEEK_LEFT, PH_SEEK_RIGHT, PH_CENTERING
    } phase_t;

    localparam int CNT_MAX = (SETTLE_CYC > SAMPLE_CYC) ? SETTLE_CYC : SAMPLE_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_CYC - 1);
    localparam logic [TAP_W-1:0] TAP_LIMIT   = TAP_W'(MAX_TAP);
    localparam logic [TAP_W:0]   MIN_WIDTH   = (TAP_W + 1)'(MIN_EYE);

    localparam logic [1:0] CODE_NO_LEFT = 2'b01;
    localparam logic [1:0] CODE_NARROW  = 2'b10;
    localparam logic [1:0] CODE_OOR     = 2'b11;

    state_t           state_q, state_d;
    phase_t           phase_q, phase_d;
    logic [TAP_W-1:0] tap_q, tap_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mv_idle_q, mv_idle_d;
    logic             err_q, err_d;
    logic [1:0]       err_code_q, err_code_d;
    logic [TAP_W-1:0] left_q, left_d;
    logic [TAP_W-1:0] right_q, right_d;
    logic [TAP_W-1:0] center_q, center_d;
    logic             retry_q, retry_d;
    logic             retry_ok;

    logic             load, move, dir, clr;
    logic             fail_hit, edge_found;
    logic [1:0]       fail_code;

    // The flags are sticky, so one look at the end of the window covers the
    // whole accumulation period.
    logic             pass;
    logic             at_limit;
    logic [TAP_W-1:0] left_cand, right_cand;
    logic [TAP_W:0]   eye_width, center_sum;

    assign pass     = !(EYE_MONITOR_EARLY || EYE_MONITOR_LATE);
    assign at_limit = (tap_q == TAP_LIMIT) || DELAY_LINE_OUT_OF_RANGE;

    // A pass at the limit while seeking left is a one-tap eye, and its left
    // edge is the current tap.
    assign left_cand  = (phase_q == PH_SEEK_LEFT) ? tap_q : left_q;
    assign right_cand = (phase_q == PH_SEEK_RIGHT && !pass) ? tap_q - 1'b1 : tap_q;
    assign eye_width  = {1'b0, right_cand} - {1'b0, left_cand} + 1'b1;
    assign center_sum = {1'b0, left_cand} + {1'b0, right_cand};

`ifdef IOD_RD_TRAIN_RETRY_EN
    assign retry_ok = !retry_q;
`else
    assign retry_ok = 1'b0;
`endif

    // Next-state, datapath-update and pulse decode for the training sequence.
    always_comb begin
        // NOTE: every variable assigned here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d    = state_q;
        phase_d    = phase_q;
        tap_d      = tap_q;
        mv_idle_d  = 1'b0;
        err_d      = err_q;
        err_code_d = err_code_q;
        left_d     = left_q;
        right_d    = right_q;
        center_d   = center_q;
        retry_d    = retry_q;
        load       = 1'b0;
        move       = 1'b0;
        dir        = 1'b0;
        clr        = 1'b0;
        fail_hit   = 1'b0;
        fail_code  = 2'b00;
        edge_found = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (START) begin
                    err_d      = 1'b0;
                    err_code_d = 2'b00;
                    retry_d    = 1'b0;
                    tap_d      = '0;
                    phase_d    = PH_SEEK_LEFT;
                    state_d    = S_LOAD;
                end
            end
            S_LOAD: begin
                load    = 1'b1;
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (cnt_q == SETTLE_LAST)
                    state_d = (phase_q == PH_CENTERING) ? S_FIN : S_CLEAR;
            end
            S_CLEAR: begin
                clr     = 1'b1;
                state_d = S_SAMPLE;
            end
            S_SAMPLE: begin
                if (cnt_q == SAMPLE_LAST)
                    state_d = S_EVAL;
            end
            S_EVAL: begin
                if (phase_q == PH_SEEK_LEFT) begin
                    if (pass) begin
                        left_d  = tap_q;
                        phase_d = PH_SEEK_RIGHT;
                        if (at_limit) edge_found = 1'b1;
                        else          state_d    = S_STEP;
                    end else if (at_limit) begin
                        fail_hit  = 1'b1;
                        fail_code = CODE_NO_LEFT;
                    end else begin
                        state_d = S_STEP;
                    end
                end else begin
                    if (!pass || at_limit) edge_found = 1'b1;
                    else                   state_d    = S_STEP;
                end

                if (edge_found) begin
                    right_d = right_cand;
                    if (eye_width < MIN_WIDTH) begin
                        fail_hit  = 1'b1;
                        fail_code = CODE_NARROW;
                    end else begin
                        center_d = center_sum[TAP_W:1];
                        phase_d  = PH_CENTERING;
                        state_d  = S_CENTER;
                    end
                end
            end
            S_STEP: begin
                move    = 1'b1;
                dir     = 1'b1;
                tap_d   = tap_q + 1'b1;
                state_d = S_SETTLE;
            end
            S_CENTER: begin
                // A move cycle is followed by one idle cycle.
                if (DELAY_LINE_OUT_OF_RANGE) begin
                    fail_hit  = 1'b1;
                    fail_code = CODE_OOR;
                end else if (tap_q == center_q) begin
                    state_d = S_SETTLE;
                end else if (!mv_idle_q) begin
                    move      = 1'b1;
                    tap_d     = tap_q - 1'b1;
                    mv_idle_d = 1'b1;
                end
            end
            S_FIN:   state_d = S_IDLE;
            S_FAIL:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // A retry restarts the sweep but keeps the delay line where it stopped.
        // LOAD then puts it back to the default tap.
        if (fail_hit) begin
            if (retry_ok && fail_code != CODE_OOR) begin
                retry_d = 1'b1;
                tap_d   = '0;
                phase_d = PH_SEEK_LEFT;
                state_d = S_LOAD;
            end else begin
                err_d      = 1'b1;
                err_code_d = fail_code;
                state_d    = S_FAIL;
            end
        end

        // The wait counter restarts on every state change.
        cnt_d = (state_d != state_q) ? '0 : cnt_q + 1'b1;
    end

    // State, sweep position and result registers.
    // NOTE: every register here is a few bits of control state, so all of
    // them take the async reset; reset mid-run returns straight to IDLE.
    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            state_q    <= S_IDLE;
            phase_q    <= PH_SEEK_LEFT;
            tap_q      <= '0;
            cnt_q      <= '0;
            mv_idle_q  <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= 2'b00;
            left_q     <= '0;
            right_q    <= '0;
            center_q   <= '0;
            retry_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so each register samples the
            // pre-edge value of every other register.
            state_q    <= state_d;
            phase_q    <= phase_d;
            tap_q      <= tap_d;
            cnt_q      <= cnt_d;
            mv_idle_q  <= mv_idle_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            left_q     <= left_d;
            right_q    <= right_d;
            center_q   <= center_d;
            retry_q    <= retry_d;
        end
    end

    // Pulses decode directly from the registered state. Reset therefore
    // silences them in the same cycle.
    assign DELAY_LINE_LOAD         = load;
    assign DELAY_LINE_MOVE         = move;
    assign DELAY_LINE_DIRECTION    = dir;
    assign EYE_MONITOR_CLEAR_FLAGS = clr;
    assign BUSY       = (state_q != S_IDLE) && (state_q != S_FIN) && (state_q != S_FAIL);
    assign DONE       = (state_q == S_FIN);
    assign ERR        = err_q;
    assign ERR_CODE   = err_code_q;
    assign LEFT_EDGE  = left_q;
    assign RIGHT_EDGE = right_q;
    assign CENTER_TAP = center_q;

endmodule
